pla_tt_sweeper: RTL and testbench

Sequential stimulus/capture stage placed directly upstream of an N_IN-input, single-output combinational PLA netlist (the optimised benchmark logic). On start it drives every input minterm 0..2^N_IN-1 onto the netlist and samples its output. It packs the resulting truth table into bytes and streams them out over a valid/ready interface. It also reports the on-set size. This lets the original and optimised netlists be checked for equivalence by comparing streams.

---
 rtl/pla_tt_sweeper.sv | 127 ++++++++++++
 tb/tb_pla_tt_sweeper.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pla_tt_sweeper.sv
// rtl/pla_tt_sweeper.sv - sweeps all minterms through a PLA netlist and streams its truth table as bytes
module pla_tt_sweeper #(
    parameter int N_IN   = 8,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] x_out,
    input  logic            y_in,
    output logic [7:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   ones_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [N_IN-1:0] IDX_MAX     = '1;
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      buf_q, buf_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic [N_IN:0]   ones_q, ones_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ones_q  <= ones_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        ones_d  = ones_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    buf_d   = '0;
                    ones_d  = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                buf_d[idx_q[2:0]] = y_in;
                ones_d = ones_q + {{N_IN{1'b0}}, y_in};
                if (idx_q[2:0] == 3'd7) begin
                    // Byte complete: the current bit is already merged into buf_d.
                    data_d  = buf_d;
                    valid_d = 1'b1;
                    last_d  = (idx_q == IDX_MAX);
                    state_d = S_EMIT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SETTLE;
                end
            end
            S_EMIT: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (idx_q == IDX_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SETTLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q == S_SETTLE) || (state_q == S_SAMPLE) || (state_q == S_EMIT);
    assign done       = (state_q == S_DONE);
    assign x_out      = busy ? idx_q : '0;
    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign out_last   = last_q;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_pla_tt_sweeper.sv
// tb/tb_pla_tt_sweeper.sv - randomized self-checking bench for pla_tt_sweeper
module tb_pla_tt_sweeper;

    localparam int N      = 8;
    localparam int NMINT  = 1 << N;
    localparam int NBYTES = NMINT / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         out_ready = 1'b1;
    logic         sel = 1'b0;
    int           mode = 0;
    logic [255:0] ttv = '0;

    logic         start_a, start_b, y_a, y_b;
    logic [N-1:0] x_a, x_b;
    logic [7:0]   data_a, data_b;
    logic         valid_a, valid_b, last_a, last_b, busy_a, busy_b, done_a, done_b;
    logic [N:0]   ones_a, ones_b;

    int checks = 0;
    int errors = 0;

    function automatic logic fval(input logic [7:0] x, input int m, input logic [255:0] t);
        case (m)
            0:       return x[0];
            1:       return &x;
            2:       return 1'b0;
            default: return t[x];
        endcase
    endfunction

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    always_comb y_a = fval(x_a, mode, ttv);
    always_comb y_b = fval(x_b, mode, ttv);

    pla_tt_sweeper #(.N_IN(N), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .x_out(x_a), .y_in(y_a),
        .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready), .out_last(last_a),
        .busy(busy_a), .done(done_a), .ones_count(ones_a)
    );

    pla_tt_sweeper #(.N_IN(N), .SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .x_out(x_b), .y_in(y_b),
        .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready), .out_last(last_b),
        .busy(busy_b), .done(done_b), .ones_count(ones_b)
    );

    logic [N-1:0] x_o;
    logic [7:0]   data_o;
    logic         valid_o, last_o, busy_o, done_o;
    logic [N:0]   ones_o;
    assign x_o     = sel ? x_b : x_a;
    assign data_o  = sel ? data_b : data_a;
    assign valid_o = sel ? valid_b : valid_a;
    assign last_o  = sel ? last_b : last_a;
    assign busy_o  = sel ? busy_b : busy_a;
    assign done_o  = sel ? done_b : done_a;
    assign ones_o  = sel ? ones_b : ones_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // rmode: 0 ready tied high, 1 random ready, 2 ten-cycle stall on byte 3.
    // abort_at: if >=0, reset is pulsed on the first cycle x_out shows that minterm.
    task automatic run_sweep(input int rmode, input int exp_done_edge,
                             input bit mid_start, input int abort_at);
        logic [7:0] got[$];
        bit         lasts[$];
        logic [7:0] exp_b;
        logic [7:0] held;
        int         exp_ones, e, done_edge;
        bit         bp_done, chk32, mid_done;
        exp_ones = 0;
        for (int m = 0; m < NMINT; m++) exp_ones += int'(fval(8'(m), mode, ttv));
        @(posedge clk); #1 start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("start_clears_done", {31'd0, done_o}, 32'd0);
        chk("start_clears_ones", 32'(ones_o), 32'd0);
        e = 0; done_edge = -1; bp_done = 0; chk32 = 0; mid_done = 0;
        while (e < 5000) begin
            start = 1'b0;
            if (done_o) begin
                done_edge = e;
                break;
            end
            if (abort_at >= 0 && busy_o && int'(x_o) == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1 rst_n = 1'b1;
                chk("rst_x", 32'(x_o), 32'd0);
                chk("rst_busy", {31'd0, busy_o}, 32'd0);
                chk("rst_valid", {31'd0, valid_o}, 32'd0);
                chk("rst_ones", 32'(ones_o), 32'd0);
                chk("rst_done", {31'd0, done_o}, 32'd0);
                return;
            end
            if (chk32) begin
                chk("resume_x32", 32'(x_o), 32'd32);
                chk32 = 0;
            end
            if (mid_start && !mid_done && busy_o && int'(x_o) == 50) begin
                start = 1'b1;
                mid_done = 1;
            end
            out_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rmode == 2 && !bp_done && valid_o && got.size() == 3) begin
                held = data_o;
                for (int j = 0; j < 10; j++) begin
                    out_ready = 1'b0;
                    @(posedge clk); e++; #1;
                    chk("bp_valid", {31'd0, valid_o}, 32'd1);
                    chk("bp_data", 32'(data_o), 32'(held));
                    chk("bp_x", 32'(x_o), 32'd31);
                end
                out_ready = 1'b1;
                bp_done = 1;
                chk32 = 1;
            end
            if (valid_o && out_ready) begin
                got.push_back(data_o);
                lasts.push_back(last_o);
            end
            @(posedge clk); e++; #1;
        end
        out_ready = 1'b1;
        chk("timeout", {31'd0, done_edge >= 0}, 32'd1);
        if (exp_done_edge >= 0) chk("done_edge", 32'(done_edge), 32'(exp_done_edge));
        chk("byte_count", 32'(got.size()), 32'(NBYTES));
        for (int k = 0; k < NBYTES && k < got.size(); k++) begin
            exp_b = '0;
            for (int i = 0; i < 8; i++) exp_b[i] = fval(8'(8 * k + i), mode, ttv);
            chk($sformatf("byte%0d", k), 32'(got[k]), 32'(exp_b));
            chk($sformatf("last%0d", k), {31'd0, lasts[k]}, {31'd0, k == NBYTES - 1});
        end
        chk("ones_count", 32'(ones_o), 32'(exp_ones));
        chk("done_high", {31'd0, done_o}, 32'd1);
        chk("x_in_done", 32'(x_o), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_x", 32'(x_o), 32'd0);
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        chk("reset_last", {31'd0, last_o}, 32'd0);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_done", {31'd0, done_o}, 32'd0);
        chk("reset_ones", 32'(ones_o), 32'd0);
        chk("reset_data", 32'(data_o), 32'd0);
        rst_n = 1'b1;

        mode = 0; run_sweep(0, 544, 0, -1);
        mode = 1; run_sweep(0, 544, 0, -1);

        mode = 3;
        for (int w = 0; w < 8; w++) ttv[w*32 +: 32] = $urandom;
        run_sweep(2, 554, 0, -1);
        run_sweep(0, 544, 1, -1);

        for (int w = 0; w < 8; w++) ttv[w*32 +: 32] = $urandom;
        run_sweep(1, -1, 0, -1);

        run_sweep(0, -1, 0, 100);
        run_sweep(0, 544, 0, -1);

        sel = 1'b1;
        mode = 2; run_sweep(0, 1056, 0, -1);
        mode = 3; run_sweep(0, 1056, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
